// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
//
// Byte-block copy engine that masters the data_mem bus. It reads `len` bytes
// starting at `src_addr` and writes them, in ascending order, starting at
// `dst_addr`. Each byte takes three cycles: RD (present the read address),
// CAP (memory returns the data, captured at the closing edge) and WR (present
// the write). The engine owns the memory bus while `busy` is high.
//
// Ports
//   clk         : clock, all state changes on the rising edge
//   rst_n       : asynchronous active-low reset
//   start       : copy request, only honoured in IDLE
//   src_addr    : first source address (latched on accepted start)
//   dst_addr    : first destination address (latched on accepted start)
//   len         : byte count 0..2^ADDR_W (latched on accepted start)
//   busy        : copy in progress
//   done        : one-cycle completion pulse (also for len = 0)
//   address_bus : memory address
//   data_in     : memory write data
//   r_w         : 1 = write, 0 = read
//   data_out    : memory read data (registered read, latency 1)
// -----------------------------------------------------------------------------
module mem_copy_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address_bus,
  output logic [DATA_W-1:0] data_in,
  output logic              r_w,
  input  logic [DATA_W-1:0] data_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_FIN
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt_q;
  logic [DATA_W-1:0] hold_q;
  logic              busy_q;
  logic              done_q;
  logic              r_w_q;
  logic [ADDR_W-1:0] addr_q;

  // Count after the byte currently being written; one bit wider than an
  // address so that a full 2^ADDR_W-byte copy can be recognised.
  logic [ADDR_W:0]   cnt_inc;
  assign cnt_inc = cnt_q + {{ADDR_W{1'b0}}, 1'b1};

  // Every output is a flop, so the memory sees clean levels all cycle long.
  // The hold register doubles as the write-data driver; it is cleared outside
  // WR so data_in reads as zero whenever no write is in flight.
  assign busy        = busy_q;
  assign done        = done_q;
  assign r_w         = r_w_q;
  assign address_bus = addr_q;
  assign data_in     = hold_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register in this block sees the pre-edge value of every other one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the asynchronous reset clears r_w at once, which cancels any
      // write still pending at the next edge; an interrupted copy never
      // reaches FIN, so done is not pulsed.
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_w_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            len_q <= len;
            cnt_q <= '0;
            if (len == '0) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              // Drive the first read address straight from the inputs, since
              // src_q is only being loaded at this same edge.
              state_q <= S_RD;
              busy_q  <= 1'b1;
              addr_q  <= src_addr;
            end
          end
        end

        S_RD: begin
          // The memory samples address_bus at this edge; its data appears
          // during CAP.
          state_q <= S_CAP;
        end

        S_CAP: begin
          state_q <= S_WR;
          hold_q  <= data_out;
          addr_q  <= dst_q + cnt_q[ADDR_W-1:0];
          r_w_q   <= 1'b1;
        end

        S_WR: begin
          // The memory performs the write at this edge.
          cnt_q  <= cnt_inc;
          r_w_q  <= 1'b0;
          hold_q <= '0;
          if (cnt_inc == len_q) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            addr_q  <= '0;
          end else begin
            state_q <= S_RD;
            addr_q  <= src_q + cnt_inc[ADDR_W-1:0];
          end
        end

        S_FIN: begin
          // start is deliberately not looked at here.
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          r_w_q   <= 1'b0;
          addr_q  <= '0;
          hold_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_engine
//
// Directed bench for mem_copy_engine. A behavioural data_mem (registered read,
// write on r_w = 1) sits on the bus. Outputs are sampled 1 ns after a rising
// edge or on the falling edge; event counters (done pulses, r_w cycles, busy
// cycles) are kept by a falling-edge monitor and compared as differences.
// -----------------------------------------------------------------------------
module tb_mem_copy_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] src_addr = '0;
  logic [7:0] dst_addr = '0;
  logic [8:0] len = '0;
  logic       busy;
  logic       done;
  logic [7:0] address_bus;
  logic [7:0] data_in;
  logic       r_w;
  logic [7:0] data_out = '0;

  logic [7:0] mem [256];

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int rw_cnt = 0;
  int busy_cnt = 0;
  int e0 = 0;

  int d0, rw0, b0;

  mem_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .address_bus (address_bus),
    .data_in     (data_in),
    .r_w         (r_w),
    .data_out    (data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory: write on r_w = 1, otherwise registered read.
  always @(posedge clk) begin
    if (r_w) mem[address_bus] <= data_in;
    else     data_out <= mem[address_bus];
  end

  always @(negedge clk) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (r_w)  rw_cnt   = rw_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, lets edge E0 accept it, and leaves the bench in the
  // cycle right after E0 (index e0).
  task automatic do_start(input logic [7:0] s, input logic [7:0] d, input logic [8:0] n);
    src_addr = s;
    dst_addr = d;
    len      = n;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e0    = cyc;
  endtask

  task automatic snap();
    d0  = done_cnt;
    rw0 = rw_cnt;
    b0  = busy_cnt;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // ---------------- reset state (asynchronous, before any clock edge) -----
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_r_w",  {31'd0, r_w},  32'd0);
    check("rst_addr", {24'd0, address_bus}, 32'd0);
    check("rst_din",  {24'd0, data_in}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // ---------------- single byte -------------------------------------------
    mem[0] = 8'd1;
    snap();
    do_start(8'h00, 8'h10, 9'd1);
    check("sb_rd_busy", {31'd0, busy}, 32'd1);
    check("sb_rd_addr", {24'd0, address_bus}, 32'h00);
    check("sb_rd_r_w",  {31'd0, r_w}, 32'd0);
    tick(); tick();   // cycle e0+2: WR
    check("sb_wr_r_w",  {31'd0, r_w}, 32'd1);
    check("sb_wr_addr", {24'd0, address_bus}, 32'h10);
    check("sb_wr_din",  {24'd0, data_in}, 32'd1);
    repeat (4) tick();
    check("sb_mem16",   {24'd0, mem[16]}, 32'd1);
    check("sb_done_lat", done_cyc - e0, 32'd3);   // cycle after edge E0+3
    check("sb_done_cnt", done_cnt - d0, 32'd1);
    check("sb_rw_cyc",   rw_cnt - rw0, 32'd1);
    check("sb_busy_cyc", busy_cnt - b0, 32'd3);

    // ---------------- block copy --------------------------------------------
    mem[0] = 8'd1; mem[1] = 8'd7; mem[2] = 8'd9; mem[3] = 8'd42;
    snap();
    do_start(8'h00, 8'h20, 9'd4);
    repeat (14) tick();
    check("bc_mem32", {24'd0, mem[32]}, 32'd1);
    check("bc_mem33", {24'd0, mem[33]}, 32'd7);
    check("bc_mem34", {24'd0, mem[34]}, 32'd9);
    check("bc_mem35", {24'd0, mem[35]}, 32'd42);
    check("bc_src0",  {24'd0, mem[0]}, 32'd1);
    check("bc_src3",  {24'd0, mem[3]}, 32'd42);
    check("bc_busy_cyc", busy_cnt - b0, 32'd12);
    check("bc_done_lat", done_cyc - e0, 32'd12);
    check("bc_done_cnt", done_cnt - d0, 32'd1);
    check("bc_rw_cyc",   rw_cnt - rw0, 32'd4);

    // ---------------- wrap-around with ascending overlap --------------------
    mem[8'hFE] = 8'd5; mem[8'hFF] = 8'd6;
    snap();
    do_start(8'hFE, 8'hFF, 9'd2);
    repeat (8) tick();
    check("wr_memFF", {24'd0, mem[8'hFF]}, 32'd5);
    check("wr_mem00", {24'd0, mem[8'h00]}, 32'd5);
    check("wr_done_cnt", done_cnt - d0, 32'd1);

    // ---------------- zero length -------------------------------------------
    snap();
    do_start(8'h00, 8'h80, 9'd0);
    check("z_done",   {31'd0, done}, 32'd1);
    check("z_busy",   {31'd0, busy}, 32'd0);
    repeat (3) tick();
    check("z_rw_cyc",   rw_cnt - rw0, 32'd0);
    check("z_done_cnt", done_cnt - d0, 32'd1);
    check("z_mem80",    {24'd0, mem[8'h80]}, 32'd0);

    // ---------------- start while busy and during FIN is ignored ------------
    snap();
    do_start(8'h20, 8'h50, 9'd2);     // copies 1,7
    tick();                            // e0+1: CAP
    src_addr = 8'h30; dst_addr = 8'h90; len = 9'd5; start = 1'b1;
    tick();                            // e0+2
    start = 1'b0;
    repeat (4) tick();                 // e0+6: FIN
    check("ig_fin_done", {31'd0, done}, 32'd1);
    start = 1'b1;
    tick();                            // e0+7: IDLE, FIN ignored the request
    start = 1'b0;
    check("ig_idle_busy", {31'd0, busy}, 32'd0);
    repeat (4) tick();
    check("ig_done_cnt",  done_cnt - d0, 32'd1);
    check("ig_busy_cyc",  busy_cnt - b0, 32'd6);
    check("ig_mem50",     {24'd0, mem[8'h50]}, 32'd1);
    check("ig_mem51",     {24'd0, mem[8'h51]}, 32'd7);
    check("ig_mem90",     {24'd0, mem[8'h90]}, 32'd0);

    // ---------------- reset mid-copy ----------------------------------------
    mem[0] = 8'd1; mem[1] = 8'd7; mem[2] = 8'd9; mem[3] = 8'd42;
    mem[8'h41] = 8'hAA;
    snap();
    do_start(8'h00, 8'h40, 9'd4);
    repeat (5) tick();                 // e0+5: WR of byte 1
    check("rm_pre_r_w",  {31'd0, r_w}, 32'd1);
    check("rm_pre_addr", {24'd0, address_bus}, 32'h41);
    rst_n = 1'b0;
    #1;
    check("rm_r_w",  {31'd0, r_w}, 32'd0);
    check("rm_busy", {31'd0, busy}, 32'd0);
    check("rm_addr", {24'd0, address_bus}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rm_mem64",    {24'd0, mem[8'h40]}, 32'd1);
    check("rm_mem65",    {24'd0, mem[8'h41]}, 32'hAA);
    check("rm_done_cnt", done_cnt - d0, 32'd0);

    snap();
    do_start(8'h00, 8'h60, 9'd3);
    repeat (11) tick();
    check("rm2_mem60", {24'd0, mem[8'h60]}, 32'd1);
    check("rm2_mem61", {24'd0, mem[8'h61]}, 32'd7);
    check("rm2_mem62", {24'd0, mem[8'h62]}, 32'd9);
    check("rm2_done_lat", done_cyc - e0, 32'd9);
    check("rm2_done_cnt", done_cnt - d0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Byte-block copy engine acting as bus master on the `data_mem` port set (`address_bus`, `data_in`, `r_w`, `data_out`). It drives the memory side of that interface: it reads `len` bytes starting at `src_addr` and writes them to `dst_addr`. It sits between the control logic and `data_mem`, and owns the memory bus while busy. It gives the team a self-checking way to exercise both memory directions without a testbench driving the bus by hand.

## Interface
- `ADDR_W`, default 8: memory address width; addresses wrap modulo 2^ADDR_W.
- `DATA_W`, default 8: memory data width.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request a copy; sampled only in IDLE.
- `src_addr` input ADDR_W: first source address; latched on accepted `start`.
- `dst_addr` input ADDR_W: first destination address; latched on accepted `start`.
- `len` input ADDR_W+1: byte count, 0 to 2^ADDR_W; latched on accepted `start`.
- `busy` output 1: high from the cycle after an accepted `start` until `done`.
- `done` output 1: one-cycle pulse when the copy completes; also fires for `len`=0.
- `address_bus` output ADDR_W: memory address; connects to `data_mem.address_bus`.
- `data_in` output DATA_W: memory write data; connects to `data_mem.data_in`.
- `r_w` output 1: 1 means write, 0 means read; connects to `data_mem.r_w`.
- `data_out` input DATA_W: memory read data from `data_mem.data_out`.

## Operation
- Memory contract:
  - When `r_w`=1, the memory writes `data_in` to `address_bus` at the rising edge.
  - When `r_w`=0, `data_out` reflects the address sampled at the previous rising edge (registered read, latency 1).
- The state machine has five states: IDLE, RD, CAP, WR, FIN.
- IDLE:
  - Outputs: `busy`=0, `r_w`=0, `address_bus`=0, `data_in`=0.
  - `start`=1 latches src, dst and len, and clears the byte counter.
  - Next state is FIN if `len`=0, otherwise RD.
- RD:
  - Drives `address_bus`=src+count and `r_w`=0.
  - Always goes to CAP.
- CAP:
  - Keeps `r_w`=0.
  - Registers `data_out` into the hold register at the closing edge.
  - Always goes to WR.
- WR:
  - Drives `address_bus`=dst+count, `data_in`=hold register, `r_w`=1.
  - Increments count at the closing edge.
  - Goes to FIN if count+1 equals len, otherwise RD.
- FIN:
  - `done`=1 and `busy`=0 for exactly this cycle.
  - Always returns to IDLE.
- Address arithmetic: src+count and dst+count are truncated to ADDR_W bits. The address wraps from 8'hFF to 8'h00 without error.
- Copy order is always ascending.
  - Overlapping regions with dst > src propagate already-written bytes. This is defined behaviour, not an error.
  - Overlapping regions with dst < src copy correctly.
- `start` while busy, or during FIN, is ignored. Latched parameters never change mid-copy.
- `r_w` is 1 only in WR. No other state may assert a write.

## Timing
- Reset values: `busy`=0, `done`=0, `r_w`=0, `address_bus`=0, `data_in`=0; state is IDLE; count, hold and latched registers are 0.
- Asserting `rst_n` low mid-copy:
  - All outputs go immediately to their reset values, asynchronously.
  - `r_w` drops in the same instant, so no further write occurs.
  - A byte already written stays written. The copy is abandoned and `done` is not pulsed.
- Accepted `start` at edge E0:
  - RD occupies the cycle after E0.
  - The byte k write occurs at edge E0+3(k+1).
- Total cycles for `len`=N (N≥1): `done` is high in the cycle following edge E0+3N. Start-to-done latency is 3N+1 cycles.
- `len`=0: `done` is high in the cycle after E0, and `r_w` never rises.
- `busy` is high for exactly 3N cycles.
- Outputs are registered-state decodes; `address_bus`, `data_in` and `r_w` are glitch-free at the memory input within a cycle.
- Back-to-back operation: `start` may be held high. The next copy is accepted at the first IDLE edge after FIN, so there is one dead cycle between jobs.

## Test plan
- Single byte:
  - Stimulus: preload mem[0]=8'd1; start with src=0, dst=8'h10, len=1.
  - Required: mem[16]=1; `done` pulses 4 cycles after start; `r_w` is high for exactly 1 cycle.
- Block copy:
  - Stimulus: preload mem[0..3]=1,7,9,42; start with src=0, dst=8'h20, len=4.
  - Required: mem[32..35]=1,7,9,42; `busy` is high for 12 cycles; source bytes unchanged.
- Wrap-around:
  - Stimulus: preload mem[8'hFE]=5, mem[8'hFF]=6; start with src=8'hFE, dst=8'hFF, len=2.
  - Required: mem[8'hFF]=5, then mem[8'h00]=5, because ascending overlap propagates the written byte.
- Zero length and ignored start:
  - Stimulus: `len`=0.
  - Required: `done` the next cycle and no write.
  - Stimulus: a second `start` pulsed mid-copy.
  - Required: it is ignored; exactly one `done`.
- Reset mid-copy:
  - Stimulus: start len=4 copying 1,7,9,42 from mem[0..3] to 8'h40; drive `rst_n`=0 two cycles after the first write.
  - Required: `r_w`=0 immediately; mem[64]=1; mem[65] is unchanged; no `done` pulse.
  - Required after release: a fresh start completes normally.
